// File: rtl/main_mem_responder_pkg.sv
// Shared constants and types for the main-memory responder slice.
//   MEM_LINE_BYTES  bytes per cache line
//   MEM_LINE_W      line width in bits
//   mem_rsp_state_e responder FSM states
package main_mem_responder_pkg;

    localparam int unsigned MEM_LINE_BYTES = 64;
    localparam int unsigned MEM_LINE_W     = MEM_LINE_BYTES * 8;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } mem_rsp_state_e;

endpackage

// File: rtl/main_mem_responder_if.sv
// Line-request / line-response bus between a memory initiator and responder.
//   req_valid_i/req_ready_o   request handshake
//   req_addr_i, req_write_i, req_data_i   request payload
//   rsp_valid_o/rsp_ready_i   response handshake
//   rsp_data_o, rsp_last_o, rsp_error_o   response payload
// Signal suffixes are named from the responder's point of view.
interface main_mem_responder_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_W     = 512
);
    logic                  req_valid_i;
    logic                  req_ready_o;
    logic [ADDR_WIDTH-1:0] req_addr_i;
    logic                  req_write_i;
    logic [DATA_W-1:0]     req_data_i;
    logic                  rsp_valid_o;
    logic                  rsp_ready_i;
    logic [DATA_W-1:0]     rsp_data_o;
    logic                  rsp_last_o;
    logic                  rsp_error_o;

    modport slave (
        input  req_valid_i, req_addr_i, req_write_i, req_data_i, rsp_ready_i,
        output req_ready_o, rsp_valid_o, rsp_data_o, rsp_last_o, rsp_error_o
    );

    modport master (
        output req_valid_i, req_addr_i, req_write_i, req_data_i, rsp_ready_i,
        input  req_ready_o, rsp_valid_o, rsp_data_o, rsp_last_o, rsp_error_o
    );
endinterface

// File: rtl/main_mem_responder_mem_line_store.sv
// Line-wide backing store with a per-line "written" bitmap.
//   clk_i, rst_i  clock / synchronous active-high reset (clears bitmap only)
//   i_rd_en       registered read of line i_idx into o_rd_data
//   i_wr_en       write i_wr_data to line i_idx and mark it written
//   o_rd_data     last read result; zero for lines never written since reset
module mem_line_store #(
    parameter int unsigned DEPTH_LINES = 4096,
    parameter int unsigned LINE_W      = 512,
    parameter int unsigned IDX_W       = $clog2(DEPTH_LINES)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              i_rd_en,
    input  logic              i_wr_en,
    input  logic [IDX_W-1:0]  i_idx,
    input  logic [LINE_W-1:0] i_wr_data,
    output logic [LINE_W-1:0] o_rd_data
);

    logic [LINE_W-1:0]      r_mem [DEPTH_LINES];
    logic [DEPTH_LINES-1:0] r_written;
    logic [LINE_W-1:0]      r_rd_data;

    // Array contents are deliberately not reset.
    always_ff @(posedge clk_i) begin
        if (i_wr_en) begin
            r_mem[i_idx] <= i_wr_data;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_written <= '0;
            r_rd_data <= '0;
        end else begin
            if (i_wr_en) begin
                r_written[i_idx] <= 1'b1;
            end
            if (i_rd_en) begin
                r_rd_data <= r_written[i_idx] ? r_mem[i_idx] : '0;
            end
        end
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/main_mem_responder.sv
// Single-outstanding memory responder serving full-line reads and writes
// with separately programmable read and write latency.
//   clk_i  clock (rising edge)
//   rst_i  synchronous active-high reset
//   bus    slave side of the line request/response interface
module main_mem_responder
    import main_mem_responder_pkg::*;
#(
    parameter int unsigned           ADDR_WIDTH    = 32,
    parameter int unsigned           LINE_BYTES    = MEM_LINE_BYTES,
    parameter int unsigned           DEPTH_LINES   = 4096,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR     = 32'h8000_0000,
    parameter int unsigned           READ_LATENCY  = 8,
    parameter int unsigned           WRITE_LATENCY = 4
) (
    input logic                 clk_i,
    input logic                 rst_i,
    main_mem_responder_if.slave bus
);

    localparam int unsigned LINE_W     = LINE_BYTES * 8;
    localparam int unsigned OFF_BITS   = $clog2(LINE_BYTES);
    localparam int unsigned IDX_W      = $clog2(DEPTH_LINES);
    localparam int unsigned FULL_IDX_W = ADDR_WIDTH - OFF_BITS;
    localparam logic [FULL_IDX_W-1:0] DEPTH_LIM = FULL_IDX_W'(DEPTH_LINES);
    localparam logic [7:0]            RD_CNT    = 8'(READ_LATENCY - 1);
    localparam logic [7:0]            WR_CNT    = 8'(WRITE_LATENCY - 1);

    mem_rsp_state_e r_state;
    mem_rsp_state_e w_next_state;

    logic              r_ready_en;
    logic [7:0]        r_cnt;
    logic              r_write;
    logic              r_err;
    logic [IDX_W-1:0]  r_idx;
    logic [LINE_W-1:0] r_wdata;

    logic [ADDR_WIDTH:0]   w_diff;
    logic [FULL_IDX_W-1:0] w_line_full;
    logic                  w_req_err;
    logic                  w_unused_off;
    logic                  w_accept;
    logic                  w_access;
    logic                  w_rd_en;
    logic                  w_wr_en;
    logic [LINE_W-1:0]     w_rd_data;

    // Extra top bit of the difference flags addresses below BASE_ADDR.
    always_comb begin
        w_diff       = {1'b0, bus.req_addr_i} - {1'b0, BASE_ADDR};
        w_line_full  = w_diff[ADDR_WIDTH-1:OFF_BITS];
        w_req_err    = w_diff[ADDR_WIDTH] || (w_line_full >= DEPTH_LIM);
        w_unused_off = ^w_diff[OFF_BITS-1:0];
    end

    always_comb begin
        w_accept = (r_state == IDLE) && r_ready_en && bus.req_valid_i;
        w_access = (r_state == WAIT) && (r_cnt == '0);
        w_rd_en  = w_access && !r_write && !r_err;
        w_wr_en  = w_access && r_write && !r_err && !rst_i;
    end

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            IDLE:    if (w_accept)        w_next_state = WAIT;
            WAIT:    if (r_cnt == '0)     w_next_state = RESP;
            RESP:    if (bus.rsp_ready_i) w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // Request capture and latency counter. r_ready_en keeps ready low for
    // every cycle rst_i is sampled high, so ready rises one cycle after it.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_ready_en <= 1'b0;
            r_cnt      <= '0;
            r_write    <= 1'b0;
            r_err      <= 1'b0;
            r_idx      <= '0;
            r_wdata    <= '0;
        end else begin
            r_ready_en <= 1'b1;
            if (w_accept) begin
                r_write <= bus.req_write_i;
                r_err   <= w_req_err;
                r_idx   <= w_line_full[IDX_W-1:0];
                r_wdata <= bus.req_data_i;
                r_cnt   <= bus.req_write_i ? WR_CNT : RD_CNT;
            end else if ((r_state == WAIT) && (r_cnt != '0)) begin
                r_cnt <= r_cnt - 8'd1;
            end
        end
    end

    // Outputs: the store's read register only updates on a read access,
    // so gating it by state keeps response data stable through RESP.
    always_comb begin
        bus.req_ready_o = (r_state == IDLE) && r_ready_en;
        bus.rsp_valid_o = (r_state == RESP);
        bus.rsp_last_o  = (r_state == RESP);
        bus.rsp_error_o = (r_state == RESP) && r_err;
        bus.rsp_data_o  = ((r_state == RESP) && !r_write && !r_err) ? w_rd_data : '0;
    end

    mem_line_store #(
        .DEPTH_LINES (DEPTH_LINES),
        .LINE_W      (LINE_W),
        .IDX_W       (IDX_W)
    ) u_store (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .i_rd_en   (w_rd_en),
        .i_wr_en   (w_wr_en),
        .i_idx     (r_idx),
        .i_wr_data (r_wdata),
        .o_rd_data (w_rd_data)
    );

endmodule

// File: tb/tb_main_mem_responder.sv
// Directed self-checking bench for main_mem_responder.
module tb_main_mem_responder;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    localparam logic [511:0] BEEF_LINE = {16{32'hDEAD_BEEF}};
    localparam logic [511:0] CAFE_LINE = {16{32'hCAFE_F00D}};
    localparam logic [511:0] L1234     = {16{32'h1234_5678}};
    localparam logic [511:0] L5A5A     = {16{32'h5A5A_A5A5}};
    localparam logic [511:0] ZERO_LINE = '0;

    always #5 clk = ~clk;

    main_mem_responder_if #(.ADDR_WIDTH(32), .DATA_W(512)) bus ();

    main_mem_responder #(
        .ADDR_WIDTH    (32),
        .LINE_BYTES    (64),
        .DEPTH_LINES   (4096),
        .BASE_ADDR     (32'h8000_0000),
        .READ_LATENCY  (8),
        .WRITE_LATENCY (4)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    // Drive a request, wait (bounded) for ready, and consume the accept edge.
    task automatic send_req(input logic [31:0] addr, input logic wr,
                            input logic [511:0] data, output bit ok);
        ok = 1'b0;
        bus.req_valid_i = 1'b1;
        bus.req_addr_i  = addr;
        bus.req_write_i = wr;
        bus.req_data_i  = data;
        for (int i = 0; i < 100; i++) begin
            if (bus.req_ready_o) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        if (ok) begin
            @(posedge clk); #1;
        end
    endtask

    // Count edges after accept until rsp_valid; lat = -1 on timeout.
    task automatic wait_rsp(output int lat, output int ready_seen);
        lat = -1;
        ready_seen = 0;
        for (int n = 1; n <= 300; n++) begin
            @(posedge clk); #1;
            if (bus.req_ready_o) ready_seen++;
            if (bus.rsp_valid_o) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic finish_rsp();
        bus.rsp_ready_i = 1'b1;
        @(posedge clk); #1;
        bus.rsp_ready_i = 1'b0;
    endtask

    task automatic do_txn(input logic [31:0] addr, input logic wr, input logic [511:0] wdata,
                          output bit ok, output int lat, output logic [511:0] data,
                          output logic err, output logic last);
        int rs;
        send_req(addr, wr, wdata, ok);
        bus.req_valid_i = 1'b0;
        wait_rsp(lat, rs);
        data = bus.rsp_data_o;
        err  = bus.rsp_error_o;
        last = bus.rsp_last_o;
        finish_rsp();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (bus.req_ready_o !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", bus.req_ready_o); end
        checks++; if (bus.rsp_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", bus.rsp_valid_o); end
        checks++; if (bus.rsp_data_o !== ZERO_LINE) begin errors++; $display("FAIL reset_data: got %h expected 0", bus.rsp_data_o); end
        checks++; if (bus.rsp_last_o !== 1'b0) begin errors++; $display("FAIL reset_last: got %b expected 0", bus.rsp_last_o); end
        checks++; if (bus.rsp_error_o !== 1'b0) begin errors++; $display("FAIL reset_error: got %b expected 0", bus.rsp_error_o); end
        rst = 1'b0;
        #1;
        checks++; if (bus.req_ready_o !== 1'b0) begin errors++; $display("FAIL ready_at_release: got %b expected 0", bus.req_ready_o); end
        @(posedge clk); #1;
        checks++; if (bus.req_ready_o !== 1'b1) begin errors++; $display("FAIL ready_after_release: got %b expected 1", bus.req_ready_o); end
    endtask

    task automatic test_unwritten_read();
        bit ok; int lat; logic [511:0] d; logic e, l;
        do_txn(32'h8000_0040, 1'b0, ZERO_LINE, ok, lat, d, e, l);
        checks++; if (!ok) begin errors++; $display("FAIL unwr_accept: got timeout expected accept"); end
        checks++; if (lat !== 8) begin errors++; $display("FAIL unwr_latency: got %0d expected 8", lat); end
        checks++; if (d !== ZERO_LINE) begin errors++; $display("FAIL unwr_data: got %h expected 0", d); end
        checks++; if (e !== 1'b0) begin errors++; $display("FAIL unwr_error: got %b expected 0", e); end
        checks++; if (l !== 1'b1) begin errors++; $display("FAIL unwr_last: got %b expected 1", l); end
    endtask

    task automatic test_write_read();
        bit ok; int lat; logic [511:0] d; logic e, l;
        do_txn(32'h8000_1000, 1'b1, BEEF_LINE, ok, lat, d, e, l);
        checks++; if (lat !== 4) begin errors++; $display("FAIL wr_latency: got %0d expected 4", lat); end
        checks++; if (e !== 1'b0) begin errors++; $display("FAIL wr_error: got %b expected 0", e); end
        checks++; if (d !== ZERO_LINE) begin errors++; $display("FAIL wr_data: got %h expected 0", d); end
        checks++; if (l !== 1'b1) begin errors++; $display("FAIL wr_last: got %b expected 1", l); end
        do_txn(32'h8000_1004, 1'b0, ZERO_LINE, ok, lat, d, e, l);
        checks++; if (lat !== 8) begin errors++; $display("FAIL raw_latency: got %0d expected 8", lat); end
        checks++; if (d !== BEEF_LINE) begin errors++; $display("FAIL raw_data: got %h expected %h", d, BEEF_LINE); end
        checks++; if (e !== 1'b0) begin errors++; $display("FAIL raw_error: got %b expected 0", e); end
        do_txn(32'h8000_2000, 1'b1, CAFE_LINE, ok, lat, d, e, l);
        checks++; if (e !== 1'b0) begin errors++; $display("FAIL wr2_error: got %b expected 0", e); end
    endtask

    task automatic test_out_of_range();
        bit ok; int lat; logic [511:0] d; logic e, l;
        do_txn(32'h7FFF_FFC0, 1'b0, ZERO_LINE, ok, lat, d, e, l);
        checks++; if (e !== 1'b1) begin errors++; $display("FAIL below_base_error: got %b expected 1", e); end
        checks++; if (d !== ZERO_LINE) begin errors++; $display("FAIL below_base_data: got %h expected 0", d); end
        checks++; if (lat !== 8) begin errors++; $display("FAIL below_base_latency: got %0d expected 8", lat); end
        do_txn(32'h8004_0000, 1'b1, L5A5A, ok, lat, d, e, l);
        checks++; if (e !== 1'b1) begin errors++; $display("FAIL past_end_error: got %b expected 1", e); end
        checks++; if (d !== ZERO_LINE) begin errors++; $display("FAIL past_end_data: got %h expected 0", d); end
        checks++; if (lat !== 4) begin errors++; $display("FAIL past_end_latency: got %0d expected 4", lat); end
        do_txn(32'h8003_FFC0, 1'b0, ZERO_LINE, ok, lat, d, e, l);
        checks++; if (e !== 1'b0) begin errors++; $display("FAIL last_line_error: got %b expected 0", e); end
        checks++; if (d !== ZERO_LINE) begin errors++; $display("FAIL last_line_data: got %h expected 0", d); end
        do_txn(32'hFFFF_FFC0, 1'b0, ZERO_LINE, ok, lat, d, e, l);
        checks++; if (e !== 1'b1) begin errors++; $display("FAIL top_addr_error: got %b expected 1", e); end
        do_txn(32'h8003_FFC0, 1'b1, L5A5A, ok, lat, d, e, l);
        checks++; if (e !== 1'b0) begin errors++; $display("FAIL last_line_wr_error: got %b expected 0", e); end
        do_txn(32'h8003_FFFF, 1'b0, ZERO_LINE, ok, lat, d, e, l);
        checks++; if (d !== L5A5A) begin errors++; $display("FAIL last_line_rd_data: got %h expected %h", d, L5A5A); end
    endtask

    task automatic test_backpressure();
        bit ok; int lat, rs;
        int bad_valid, bad_data, bad_ready;
        send_req(32'h8000_1000, 1'b0, ZERO_LINE, ok);
        bus.req_valid_i = 1'b0;
        wait_rsp(lat, rs);
        checks++; if (lat !== 8) begin errors++; $display("FAIL bp_latency: got %0d expected 8", lat); end
        bad_valid = 0; bad_data = 0; bad_ready = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (bus.rsp_valid_o !== 1'b1) bad_valid++;
            if (bus.rsp_data_o !== BEEF_LINE) bad_data++;
            if (bus.req_ready_o !== 1'b0) bad_ready++;
        end
        checks++; if (bad_valid != 0) begin errors++; $display("FAIL bp_valid_held: got %0d drops expected 0", bad_valid); end
        checks++; if (bad_data != 0) begin errors++; $display("FAIL bp_data_stable: got %0d bad cycles expected 0", bad_data); end
        checks++; if (bad_ready != 0) begin errors++; $display("FAIL bp_ready_low: got %0d high cycles expected 0", bad_ready); end
        finish_rsp();
        checks++; if (bus.rsp_valid_o !== 1'b0) begin errors++; $display("FAIL bp_valid_clear: got %b expected 0", bus.rsp_valid_o); end
        checks++; if (bus.req_ready_o !== 1'b1) begin errors++; $display("FAIL bp_ready_return: got %b expected 1", bus.req_ready_o); end
    endtask

    task automatic test_busy_ignore();
        bit ok; int lat, rs;
        send_req(32'h8000_1000, 1'b0, ZERO_LINE, ok);
        bus.req_addr_i = 32'h8000_2000;   // next request held pending, valid stays high
        wait_rsp(lat, rs);
        checks++; if (lat !== 8) begin errors++; $display("FAIL busy_a_latency: got %0d expected 8", lat); end
        checks++; if (rs !== 0) begin errors++; $display("FAIL busy_extra_ready: got %0d expected 0", rs); end
        checks++; if (bus.rsp_data_o !== BEEF_LINE) begin errors++; $display("FAIL busy_a_data: got %h expected %h", bus.rsp_data_o, BEEF_LINE); end
        finish_rsp();
        checks++; if (bus.rsp_valid_o !== 1'b0) begin errors++; $display("FAIL busy_no_overlap: got %b expected 0", bus.rsp_valid_o); end
        checks++; if (bus.req_ready_o !== 1'b1) begin errors++; $display("FAIL busy_ready_b: got %b expected 1", bus.req_ready_o); end
        @(posedge clk); #1;
        bus.req_valid_i = 1'b0;
        wait_rsp(lat, rs);
        checks++; if (lat !== 8) begin errors++; $display("FAIL busy_b_latency: got %0d expected 8", lat); end
        checks++; if (bus.rsp_data_o !== CAFE_LINE) begin errors++; $display("FAIL busy_b_data: got %h expected %h", bus.rsp_data_o, CAFE_LINE); end
        finish_rsp();
    endtask

    task automatic test_reset_mid_wait();
        bit ok; int lat; logic [511:0] d; logic e, l;
        send_req(32'h8000_3000, 1'b1, L1234, ok);
        bus.req_valid_i = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        checks++; if (bus.req_ready_o !== 1'b0) begin errors++; $display("FAIL mid_rst_ready: got %b expected 0", bus.req_ready_o); end
        checks++; if (bus.rsp_valid_o !== 1'b0) begin errors++; $display("FAIL mid_rst_valid: got %b expected 0", bus.rsp_valid_o); end
        checks++; if (bus.rsp_last_o !== 1'b0) begin errors++; $display("FAIL mid_rst_last: got %b expected 0", bus.rsp_last_o); end
        checks++; if (bus.rsp_error_o !== 1'b0) begin errors++; $display("FAIL mid_rst_error: got %b expected 0", bus.rsp_error_o); end
        checks++; if (bus.rsp_data_o !== ZERO_LINE) begin errors++; $display("FAIL mid_rst_data: got %h expected 0", bus.rsp_data_o); end
        rst = 1'b0;
        @(posedge clk); #1;
        checks++; if (bus.req_ready_o !== 1'b1) begin errors++; $display("FAIL mid_rst_ready_back: got %b expected 1", bus.req_ready_o); end
        do_txn(32'h8000_3000, 1'b0, ZERO_LINE, ok, lat, d, e, l);
        checks++; if (d !== ZERO_LINE) begin errors++; $display("FAIL lost_write_data: got %h expected 0", d); end
        checks++; if (lat !== 8) begin errors++; $display("FAIL lost_write_latency: got %0d expected 8", lat); end
        // Committed write, then reset: written bit cleared so read returns zero.
        do_txn(32'h8000_4000, 1'b1, L1234, ok, lat, d, e, l);
        do_txn(32'h8000_4000, 1'b0, ZERO_LINE, ok, lat, d, e, l);
        checks++; if (d !== L1234) begin errors++; $display("FAIL committed_pre_rst: got %h expected %h", d, L1234); end
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
        do_txn(32'h8000_4000, 1'b0, ZERO_LINE, ok, lat, d, e, l);
        checks++; if (d !== ZERO_LINE) begin errors++; $display("FAIL committed_post_rst: got %h expected 0", d); end
    endtask

    initial begin
        bus.req_valid_i = 1'b0;
        bus.req_addr_i  = '0;
        bus.req_write_i = 1'b0;
        bus.req_data_i  = '0;
        bus.rsp_ready_i = 1'b0;
        test_reset();
        test_unwritten_read();
        test_write_read();
        test_out_of_range();
        test_backpressure();
        test_busy_ignore();
        test_reset_mid_wait();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
